// File: rtl/gpio_reg_arb_if.sv
// Register-bus link used on both sides of the GPIO register arbiter.
// Request fields flow master->slave; rdata/ack/err flow back.
interface gpio_reg_arb_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic            cs;
    logic            wr;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   rdata;
    logic            ack;
    logic            err;

    modport master (output cs, wr, addr, wdata, be, input rdata, ack, err);
    modport slave  (input cs, wr, addr, wdata, be, output rdata, ack, err);
    // Request side of a link whose slave never reports errors (GPIO register block).
    modport initiator (output cs, wr, addr, wdata, be, input rdata, ack);
endinterface

// File: rtl/gpio_reg_arb.sv
// Round-robin arbiter sharing the GPIO register slave between two masters,
// with a watchdog that completes unacknowledged transactions with an error ack.
module gpio_reg_arb #(
    parameter int AW      = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 mclk,
    input  logic                 h_reset,
    gpio_reg_arb_if.slave        m0,
    gpio_reg_arb_if.slave        m1,
    gpio_reg_arb_if.initiator    regb,
    output logic                 arb_owner,
    output logic                 arb_tmo
);
    localparam int BW = DW / 8;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT, DONE} state_t;

    state_t               state_q, state_d;
    logic                 reg_cs_q, reg_cs_d;
    logic                 reg_wr_q, reg_wr_d;
    logic [AW-1:0]        reg_addr_q, reg_addr_d;
    logic [DW-1:0]        reg_wdata_q, reg_wdata_d;
    logic [BW-1:0]        reg_be_q, reg_be_d;
    logic                 owner_q, owner_d;
    logic                 last_owner_q, last_owner_d;
    logic [7:0]           tmo_cnt_q, tmo_cnt_d;
    logic [1:0]           ack_q, ack_d;
    logic [1:0]           err_q, err_d;
    logic [1:0][DW-1:0]   rdata_q, rdata_d;
    logic                 tmo_q, tmo_d;
    logic                 grant;

    // On a tie the master that was not served last wins.
    assign grant = (m0.cs && m1.cs) ? ~last_owner_q : m1.cs;

    always_comb begin
        state_d      = state_q;
        reg_cs_d     = reg_cs_q;
        reg_wr_d     = reg_wr_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        reg_be_d     = reg_be_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        tmo_cnt_d    = tmo_cnt_q;
        ack_d        = '0;
        err_d        = '0;
        rdata_d      = '0;
        tmo_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m0.cs || m1.cs) begin
                    reg_cs_d    = 1'b1;
                    reg_wr_d    = grant ? m1.wr    : m0.wr;
                    reg_addr_d  = grant ? m1.addr  : m0.addr;
                    reg_wdata_d = grant ? m1.wdata : m0.wdata;
                    reg_be_d    = grant ? m1.be    : m0.be;
                    owner_d     = grant;
                    tmo_cnt_d   = '0;
                    state_d     = GNT;
                end
            end
            GNT: begin
                // A slave ack in the watchdog's last cycle still counts as success.
                if (regb.ack) begin
                    reg_cs_d         = 1'b0;
                    ack_d[owner_q]   = 1'b1;
                    rdata_d[owner_q] = reg_wr_q ? '0 : regb.rdata;
                    state_d          = DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    reg_cs_d       = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    err_d[owner_q] = 1'b1;
                    tmo_d          = 1'b1;
                    state_d        = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            state_q      <= IDLE;
            reg_cs_q     <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            reg_be_q     <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            tmo_cnt_q    <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            reg_cs_q     <= reg_cs_d;
            reg_wr_q     <= reg_wr_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            reg_be_q     <= reg_be_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            tmo_cnt_q    <= tmo_cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            tmo_q        <= tmo_d;
        end
    end

    assign regb.cs    = reg_cs_q;
    assign regb.wr    = reg_wr_q;
    assign regb.addr  = reg_addr_q;
    assign regb.wdata = reg_wdata_q;
    assign regb.be    = reg_be_q;

    assign m0.ack   = ack_q[0];
    assign m0.err   = err_q[0];
    assign m0.rdata = rdata_q[0];
    assign m1.ack   = ack_q[1];
    assign m1.err   = err_q[1];
    assign m1.rdata = rdata_q[1];

    assign arb_owner = owner_q;
    assign arb_tmo   = tmo_q;
endmodule

// File: tb/tb_gpio_reg_arb.sv
// Scoreboard bench for gpio_reg_arb: transaction-level model predicts grant
// order, ack cycle, rdata and err; a slave model checks the forwarded request.
module tb_gpio_reg_arb;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TIMEOUT = 16;

    logic mclk = 1'b0;
    logic h_reset = 1'b1;
    logic arb_owner, arb_tmo;

    always #5 mclk = ~mclk;

    gpio_reg_arb_if #(.AW(AW), .DW(DW)) m0_if ();
    gpio_reg_arb_if #(.AW(AW), .DW(DW)) m1_if ();
    gpio_reg_arb_if #(.AW(AW), .DW(DW)) reg_if ();

    assign reg_if.err = 1'b0;

    gpio_reg_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .mclk      (mclk),
        .h_reset   (h_reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .regb      (reg_if),
        .arb_owner (arb_owner),
        .arb_tmo   (arb_tmo)
    );

    typedef struct {
        int            m;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] sdata;
        int            lat;      // GNT cycle in which the slave acks; 0 = never
        int            cs_cyc;   // expected number of reg_cs cycles
    } plan_t;

    typedef struct {
        int            m;
        logic [DW-1:0] rdata;
        bit            err;
        int            ack_cyc;
    } exp_t;

    plan_t plan_q[$];
    exp_t  sb_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    last_owner = 1;

    always @(posedge mclk) cyc <= cyc + 1;

    function automatic plan_t mk(int m, bit wr, int addr, logic [DW-1:0] wd, int be,
                                 logic [DW-1:0] sd, int lat);
        plan_t p;
        p.m = m; p.wr = wr; p.addr = AW'(addr); p.wdata = wd; p.be = BW'(be);
        p.sdata = sd; p.lat = lat; p.cs_cyc = 0;
        return p;
    endfunction

    function automatic plan_t rnd_plan(int m);
        int r, lat;
        r = $urandom_range(0, 9);
        lat = (r == 0) ? 0 : (r == 1) ? TIMEOUT : $urandom_range(1, 5);
        return mk(m, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
                  $urandom_range(0, 15), $urandom, lat);
    endfunction

    task automatic drive(int m, plan_t p);
        if (m == 0) begin
            m0_if.cs = 1'b1; m0_if.wr = p.wr; m0_if.addr = p.addr;
            m0_if.wdata = p.wdata; m0_if.be = p.be;
        end else begin
            m1_if.cs = 1'b1; m1_if.wr = p.wr; m1_if.addr = p.addr;
            m1_if.wdata = p.wdata; m1_if.be = p.be;
        end
    endtask

    // One arbitration round: the model decides the service order, then queues
    // the slave plans and expected responses before the masters raise cs.
    task automatic round(bit r0, bit r1, plan_t p0, plan_t p1, bit drop, bit rel_rst);
        int first, n, start, eff, t0, bound;
        int order[2];
        bit pend0, pend1;
        plan_t p;
        exp_t e;
        p0.m = 0; p1.m = 1;
        first = (r0 && r1) ? ((last_owner == 1) ? 0 : 1) : (r0 ? 0 : 1);
        n = (r0 && r1) ? 2 : 1;
        order[0] = first; order[1] = 1 - first;
        @(negedge mclk);
        if (rel_rst) begin
            n_vec++;
            if (reg_if.cs !== 1'b0 || m0_if.ack !== 1'b0 || m1_if.ack !== 1'b0 ||
                arb_owner !== 1'b0 || arb_tmo !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid: reg_cs=%b m0_ack=%b m1_ack=%b owner=%b tmo=%b, required all 0",
                         reg_if.cs, m0_if.ack, m1_if.ack, arb_owner, arb_tmo);
            end
            h_reset = 1'b0;
        end
        t0 = cyc;
        start = t0 + 1;
        for (int i = 0; i < n; i++) begin
            p = (order[i] == 0) ? p0 : p1;
            eff = (p.lat == 0) ? TIMEOUT : p.lat;
            p.cs_cyc = eff;
            plan_q.push_back(p);
            e.m = p.m;
            e.err = (p.lat == 0);
            e.rdata = (p.wr || p.lat == 0) ? '0 : p.sdata;
            e.ack_cyc = start + eff;
            sb_q.push_back(e);
            start = start + eff + 2;
            last_owner = p.m;
        end
        if (r0) drive(0, p0);
        if (r1) drive(1, p1);
        pend0 = r0; pend1 = r1;
        bound = 2 * (TIMEOUT + 4) + 8;
        for (int k = 0; k < bound && (pend0 || pend1); k++) begin
            @(negedge mclk);
            if (pend0 && m0_if.ack === 1'b1) begin m0_if.cs = 1'b0; pend0 = 1'b0; end
            if (pend1 && m1_if.ack === 1'b1) begin m1_if.cs = 1'b0; pend1 = 1'b0; end
            // The granted master may drop cs mid-transaction; it must still be acked.
            if (drop && k == 1) begin
                if (first == 0 && pend0) m0_if.cs = 1'b0;
                if (first == 1 && pend1) m1_if.cs = 1'b0;
            end
        end
        if (pend0 || pend1) begin
            n_vec++; n_bad++;
            $display("FAIL round_done: pending m0=%b m1=%b after %0d cycles, required no pending",
                     pend0, pend1, bound);
            m0_if.cs = 1'b0; m1_if.cs = 1'b0;
        end
        repeat ($urandom_range(1, 3)) @(negedge mclk);
    endtask

    // Slave model: acks per plan and checks the forwarded request every reg_cs cycle.
    plan_t cur;
    bit    s_act = 1'b0;
    int    s_cnt = 0;
    always @(negedge mclk) begin
        if (reg_if.cs === 1'b1) begin
            if (!s_act) begin
                if (plan_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL slave_plan: reg_cs=1 with no grant expected");
                    cur = mk(-1, 1'b0, 0, '0, 0, '0, 0);
                    cur.cs_cyc = -1;
                end else begin
                    cur = plan_q.pop_front();
                end
                s_act = 1'b1;
                s_cnt = 0;
            end
            s_cnt++;
            n_vec++;
            if (reg_if.wr !== cur.wr || reg_if.addr !== cur.addr || reg_if.wdata !== cur.wdata ||
                reg_if.be !== cur.be || arb_owner !== 1'(cur.m)) begin
                n_bad++;
                $display("FAIL reg_fwd: wr=%b addr=%h wdata=%h be=%h owner=%b, required %b %h %h %h %0d",
                         reg_if.wr, reg_if.addr, reg_if.wdata, reg_if.be, arb_owner,
                         cur.wr, cur.addr, cur.wdata, cur.be, cur.m);
            end
            reg_if.ack = (cur.lat == s_cnt);
            reg_if.rdata = (cur.lat == s_cnt) ? cur.sdata : DW'($urandom);
        end else begin
            if (s_act) begin
                n_vec++;
                if (s_cnt != cur.cs_cyc) begin
                    n_bad++;
                    $display("FAIL reg_cs_len: %0d cycles, required %0d", s_cnt, cur.cs_cyc);
                end
                s_act = 1'b0;
            end
            reg_if.ack = 1'b0;
            reg_if.rdata = DW'($urandom);
        end
    end

    task automatic chk_port(int m, logic ack, logic err, logic [DW-1:0] rd);
        exp_t e;
        n_vec++;
        if (ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL ack_unexp: m%0d_ack=1 at cycle %0d, required 0", m, cyc);
            end else begin
                e = sb_q.pop_front();
                if (e.m != m || err !== e.err || rd !== e.rdata || arb_tmo !== e.err ||
                    arb_owner !== 1'(m) || cyc != e.ack_cyc) begin
                    n_bad++;
                    $display("FAIL ack_resp: m%0d cyc=%0d err=%b rdata=%h tmo=%b owner=%b, required m%0d cyc=%0d err=%b rdata=%h tmo=%b",
                             m, cyc, err, rd, arb_tmo, arb_owner, e.m, e.ack_cyc, e.err, e.rdata, e.err);
                end
            end
        end else if (ack !== 1'b0 || err !== 1'b0 || rd !== '0) begin
            n_bad++;
            $display("FAIL idle_out: m%0d ack=%b err=%b rdata=%h, required 0 0 0", m, ack, err, rd);
        end
    endtask

    always @(negedge mclk) begin
        chk_port(0, m0_if.ack, m0_if.err, m0_if.rdata);
        chk_port(1, m1_if.ack, m1_if.err, m1_if.rdata);
        if (m0_if.ack !== 1'b1 && m1_if.ack !== 1'b1) begin
            n_vec++;
            if (arb_tmo !== 1'b0) begin
                n_bad++;
                $display("FAIL tmo_idle: arb_tmo=%b without ack, required 0", arb_tmo);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog");
    end

    initial begin
        plan_t pa, pb;
        m0_if.cs = 1'b0; m0_if.wr = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.be = '0;
        m1_if.cs = 1'b0; m1_if.wr = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.be = '0;
        repeat (3) @(negedge mclk);
        n_vec++;
        if (reg_if.cs !== 1'b0 || reg_if.wr !== 1'b0 || reg_if.addr !== '0 ||
            reg_if.wdata !== '0 || reg_if.be !== '0) begin
            n_bad++;
            $display("FAIL rst_reg: cs=%b wr=%b addr=%h wdata=%h be=%h, required all 0",
                     reg_if.cs, reg_if.wr, reg_if.addr, reg_if.wdata, reg_if.be);
        end
        n_vec++;
        if (arb_owner !== 1'b0 || arb_tmo !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_arb: owner=%b tmo=%b, required 0 0", arb_owner, arb_tmo);
        end
        h_reset = 1'b0;
        last_owner = 1;

        // Ties right after reset: m0 first, and again m0 after m1 was served last.
        round(1, 1, mk(0, 0, 1, '0, 15, 32'h1111_0000, 2), mk(1, 0, 2, '0, 15, 32'h2222_0000, 2), 0, 0);
        round(1, 1, mk(0, 0, 4, '0, 15, 32'h3333_0000, 2), mk(1, 0, 5, '0, 15, 32'h4444_0000, 2), 0, 0);
        round(1, 0, mk(0, 0, 3, '0, 15, 32'hA5A5_0001, 2), pa, 0, 0);
        round(0, 1, pa, mk(1, 0, 9, '0, 15, 32'hDEAD_BEEF, 0), 0, 0);
        round(1, 0, mk(0, 0, 7, '0, 15, 32'h0BAD_F00D, 3), pa, 0, 0);
        round(1, 0, mk(0, 0, 8, '0, 15, 32'h1234_5678, TIMEOUT), pa, 0, 0);
        round(0, 1, pa, mk(1, 1, 6, 32'h0000_00FF, 4'b0001, 32'hFFFF_FFFF, 2), 0, 0);

        for (int i = 0; i < 120; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            round(pat[0], pat[1], rnd_plan(0), rnd_plan(1), ($urandom_range(0, 3) == 0), 0);
        end

        // Reset in the 2nd GNT cycle of an m1 transaction that would never be acked.
        pa = mk(1, 0, 5, 32'h5555_AAAA, 15, 32'h7777_7777, 0);
        pa.cs_cyc = 2;
        plan_q.push_back(pa);
        @(negedge mclk);
        drive(1, pa);
        @(negedge mclk);
        @(negedge mclk);
        h_reset = 1'b1;
        last_owner = 1;
        pb = pa;
        pb.sdata = 32'h8888_1234;
        pb.lat = 2;
        round(1, 1, rnd_plan(0), pb, 0, 1);

        repeat (5) @(negedge mclk);
        n_vec++;
        if (sb_q.size() != 0 || plan_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses and %0d grants outstanding, required 0 0",
                     sb_q.size(), plan_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
